// File: rtl/seg_display_scheduler.sv
// Shares the 8-digit seven-segment driver between a background value and two
// timed message sources (info, alert), with preemption, blinking and replay.
module seg_display_scheduler #(
   parameter int TICK_DIV = 100_000,
   parameter int BLINK_MS = 250
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] bg_data,
   input  logic [1:0]  bg_mode,
   input  logic        req1,
   input  logic        req2,
   input  logic [31:0] msg1_data,
   input  logic [31:0] msg2_data,
   input  logic [1:0]  msg1_mode,
   input  logic [1:0]  msg2_mode,
   input  logic [15:0] msg1_dur,
   input  logic [15:0] msg2_dur,
   input  logic        msg1_blink,
   input  logic        msg2_blink,
   input  logic        clr_msg,
   output logic [31:0] w_seg_data,
   output logic [1:0]  w_seg_mode,
   output logic [1:0]  active_src,
   output logic        done1,
   output logic        done2,
   output logic        busy
);

   // state | meaning
   // IDLE  | background word shown, no message pending
   // SHOW1 | info message shown (slot 1)
   // SHOW2 | alert message shown (slot 2), may have preempted slot 1
   typedef enum logic [1:0] {IDLE = 2'd0, SHOW1 = 2'd1, SHOW2 = 2'd2} state_t;

   localparam logic [16:0] PRESC_TC = 17'(TICK_DIV - 1);
   localparam logic [15:0] BLINK_TC = 16'(BLINK_MS - 1);

   state_t      state, state_nxt;
   logic        pend1, pend2, pend1_nxt, pend2_nxt;
   logic [31:0] data1, data2, data1_nxt, data2_nxt;
   logic [1:0]  mode1, mode2, mode1_nxt, mode2_nxt;
   logic [15:0] dur1, dur2, dur1_nxt, dur2_nxt;
   logic        blink1, blink2, blink1_nxt, blink2_nxt;
   logic [16:0] presc, presc_nxt;
   logic [15:0] ms_cnt, ms_nxt, blink_cnt, blink_cnt_nxt;
   logic        phase_on, phase_nxt;
   logic [15:0] dur_cur;
   logic        ms_tick, tc, comp1, comp2, restart, sel_blink;
   logic [31:0] out_data;
   logic [1:0]  out_mode;

   always_comb begin
      data1_nxt  = data1;
      mode1_nxt  = mode1;
      dur1_nxt   = dur1;
      blink1_nxt = blink1;
      data2_nxt  = data2;
      mode2_nxt  = mode2;
      dur2_nxt   = dur2;
      blink2_nxt = blink2;
      if (req1 && !clr_msg) begin
         data1_nxt  = msg1_data;
         mode1_nxt  = msg1_mode;
         dur1_nxt   = msg1_dur;
         blink1_nxt = msg1_blink;
      end
      if (req2 && !clr_msg) begin
         data2_nxt  = msg2_data;
         mode2_nxt  = msg2_mode;
         dur2_nxt   = msg2_dur;
         blink2_nxt = msg2_blink;
      end

      // A same-cycle request of the shown source wins over its completion.
      dur_cur = (state == SHOW2) ? dur2 : dur1;
      ms_tick = (presc == PRESC_TC);
      tc      = ms_tick && (dur_cur != 16'd0) && (ms_cnt == dur_cur - 16'd1);
      comp1   = !clr_msg && (state == SHOW1) && !req1 && tc;
      comp2   = !clr_msg && (state == SHOW2) && !req2 && tc;

      if (clr_msg) begin
         pend1_nxt = 1'b0;
         pend2_nxt = 1'b0;
      end else begin
         pend1_nxt = req1 | (pend1 & ~comp1);
         pend2_nxt = req2 | (pend2 & ~comp2);
      end

      if (pend2_nxt)      state_nxt = SHOW2;
      else if (pend1_nxt) state_nxt = SHOW1;
      else                state_nxt = IDLE;

      restart = (state_nxt != state) ||
                ((state_nxt == SHOW1) && req1) ||
                ((state_nxt == SHOW2) && req2);

      presc_nxt     = 17'd0;
      ms_nxt        = 16'd0;
      blink_cnt_nxt = 16'd0;
      phase_nxt     = 1'b1;
      if (state_nxt != IDLE && !restart) begin
         phase_nxt = phase_on;
         if (ms_tick) begin
            ms_nxt = ms_cnt + 16'd1;
            if (blink_cnt == BLINK_TC) begin
               phase_nxt = ~phase_on;
            end else begin
               blink_cnt_nxt = blink_cnt + 16'd1;
            end
         end else begin
            presc_nxt     = presc + 17'd1;
            ms_nxt        = ms_cnt;
            blink_cnt_nxt = blink_cnt;
         end
      end

      case (state_nxt)
         SHOW1: begin
            out_data  = data1_nxt;
            out_mode  = mode1_nxt;
            sel_blink = blink1_nxt;
         end
         SHOW2: begin
            out_data  = data2_nxt;
            out_mode  = mode2_nxt;
            sel_blink = blink2_nxt;
         end
         default: begin
            out_data  = bg_data;
            out_mode  = bg_mode;
            sel_blink = 1'b0;
         end
      endcase
      if (sel_blink && !phase_nxt) begin
         out_data = 32'hFFFF_FFFF;
         out_mode = 2'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pend1      <= 1'b0;
         pend2      <= 1'b0;
         data1      <= '0;
         mode1      <= '0;
         dur1       <= '0;
         blink1     <= 1'b0;
         data2      <= '0;
         mode2      <= '0;
         dur2       <= '0;
         blink2     <= 1'b0;
         presc      <= '0;
         ms_cnt     <= '0;
         blink_cnt  <= '0;
         phase_on   <= 1'b1;
         w_seg_data <= '0;
         w_seg_mode <= '0;
         active_src <= '0;
         done1      <= 1'b0;
         done2      <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         pend1      <= pend1_nxt;
         pend2      <= pend2_nxt;
         data1      <= data1_nxt;
         mode1      <= mode1_nxt;
         dur1       <= dur1_nxt;
         blink1     <= blink1_nxt;
         data2      <= data2_nxt;
         mode2      <= mode2_nxt;
         dur2       <= dur2_nxt;
         blink2     <= blink2_nxt;
         presc      <= presc_nxt;
         ms_cnt     <= ms_nxt;
         blink_cnt  <= blink_cnt_nxt;
         phase_on   <= phase_nxt;
         w_seg_data <= out_data;
         w_seg_mode <= out_mode;
         active_src <= state_nxt;
         done1      <= comp1;
         done2      <= comp2;
         busy       <= pend1_nxt | pend2_nxt;
      end
   end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// every cycle against an elapsed-time model of the message scheduler.
module tb_seg_display_scheduler;
   localparam int TD  = 10;
   localparam int BMS = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] bg_data = 32'h0000_1234;
   logic [1:0]  bg_mode = 2'd0;
   logic        req1 = 1'b0, req2 = 1'b0, clr_msg = 1'b0;
   logic [31:0] msg1_data = '0, msg2_data = '0;
   logic [1:0]  msg1_mode = '0, msg2_mode = '0;
   logic [15:0] msg1_dur = '0, msg2_dur = '0;
   logic        msg1_blink = 1'b0, msg2_blink = 1'b0;
   logic [31:0] w_seg_data;
   logic [1:0]  w_seg_mode, active_src;
   logic        done1, done2, busy;

   int checks = 0;
   int errors = 0;

   seg_display_scheduler #(.TICK_DIV(TD), .BLINK_MS(BMS)) dut (
      .clk(clk), .rst_n(rst_n), .bg_data(bg_data), .bg_mode(bg_mode),
      .req1(req1), .req2(req2),
      .msg1_data(msg1_data), .msg2_data(msg2_data),
      .msg1_mode(msg1_mode), .msg2_mode(msg2_mode),
      .msg1_dur(msg1_dur), .msg2_dur(msg2_dur),
      .msg1_blink(msg1_blink), .msg2_blink(msg2_blink),
      .clr_msg(clr_msg),
      .w_seg_data(w_seg_data), .w_seg_mode(w_seg_mode), .active_src(active_src),
      .done1(done1), .done2(done2), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: which source is shown, and cycles elapsed since its timer restart.
   int          m_cur, m_el;
   bit          m_p1, m_p2, m_b1, m_b2;
   logic [31:0] m_d1, m_d2;
   logic [1:0]  m_m1, m_m2;
   int          m_dur1, m_dur2;
   logic [31:0] exp_data;
   logic [1:0]  exp_mode, exp_src;
   logic        exp_busy, exp_done1, exp_done2;

   task automatic model_step();
      bit c1, c2, blk;
      int nxt;
      exp_done1 = 1'b0;
      exp_done2 = 1'b0;
      if (clr_msg) begin
         m_p1 = 0;
         m_p2 = 0;
         nxt  = 0;
      end else begin
         c1 = (m_cur == 1) && !req1 && (m_dur1 != 0) && (m_el + 1 == m_dur1 * TD);
         c2 = (m_cur == 2) && !req2 && (m_dur2 != 0) && (m_el + 1 == m_dur2 * TD);
         if (c1) begin m_p1 = 0; exp_done1 = 1'b1; end
         if (c2) begin m_p2 = 0; exp_done2 = 1'b1; end
         if (req1) begin
            m_d1 = msg1_data; m_m1 = msg1_mode; m_dur1 = int'(msg1_dur); m_b1 = msg1_blink; m_p1 = 1;
         end
         if (req2) begin
            m_d2 = msg2_data; m_m2 = msg2_mode; m_dur2 = int'(msg2_dur); m_b2 = msg2_blink; m_p2 = 1;
         end
         nxt = m_p2 ? 2 : (m_p1 ? 1 : 0);
      end
      if (nxt == 0 || nxt != m_cur || (nxt == 1 && req1 && !clr_msg) || (nxt == 2 && req2 && !clr_msg))
         m_el = 0;
      else
         m_el++;
      m_cur    = nxt;
      exp_src  = 2'(nxt);
      exp_busy = m_p1 | m_p2;
      if (nxt == 0) begin
         exp_data = bg_data;
         exp_mode = bg_mode;
      end else begin
         exp_data = (nxt == 1) ? m_d1 : m_d2;
         exp_mode = (nxt == 1) ? m_m1 : m_m2;
         blk      = (nxt == 1) ? m_b1 : m_b2;
         if (blk && ((m_el / (BMS * TD)) % 2 == 1)) begin
            exp_data = 32'hFFFF_FFFF;
            exp_mode = 2'd0;
         end
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cur = 0; m_el = 0; m_p1 = 0; m_p2 = 0; m_b1 = 0; m_b2 = 0;
         m_d1 = '0; m_d2 = '0; m_m1 = '0; m_m2 = '0; m_dur1 = 0; m_dur2 = 0;
         exp_data = '0; exp_mode = '0; exp_src = '0;
         exp_busy = 1'b0; exp_done1 = 1'b0; exp_done2 = 1'b0;
      end else begin
         model_step();
      end
   end

   always @(negedge clk) begin
      check("m_data",  w_seg_data, exp_data);
      check("m_mode",  32'(w_seg_mode), 32'(exp_mode));
      check("m_src",   32'(active_src), 32'(exp_src));
      check("m_busy",  32'(busy),  32'(exp_busy));
      check("m_done1", 32'(done1), 32'(exp_done1));
      check("m_done2", 32'(done2), 32'(exp_done2));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n1, n2;
      logic [31:0] want;

      // Reset and background pass-through
      repeat (3) tick();
      check("rst_data", w_seg_data, 32'h0);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      tick();
      check("bg_data", w_seg_data, 32'h0000_1234);
      check("bg_src", 32'(active_src), 32'd0);
      check("bg_busy", 32'(busy), 32'd0);
      bg_data = 32'h0000_5678;
      tick();
      check("bg_pass", w_seg_data, 32'h0000_5678);
      bg_data = 32'h0000_1234;
      tick();

      // Basic info message, dur 3
      msg1_data = 32'hFFFF_FFF2; msg1_mode = 2'd1; msg1_dur = 16'd3; msg1_blink = 1'b0; req1 = 1'b1;
      tick();
      req1 = 1'b0;
      check("m1_data", w_seg_data, 32'hFFFF_FFF2);
      check("m1_mode", 32'(w_seg_mode), 32'd1);
      check("m1_src", 32'(active_src), 32'd1);
      check("m1_busy", 32'(busy), 32'd1);
      for (int k = 1; k <= 30; k++) begin
         tick();
         check("m1_done_timing", 32'(done1), (k == 30) ? 32'd1 : 32'd0);
      end
      check("m1_back_src", 32'(active_src), 32'd0);
      check("m1_back_data", w_seg_data, 32'h0000_1234);
      repeat (3) tick();

      // Preemption and replay
      msg1_data = 32'hFFFF_FFF3; msg1_mode = 2'd1; msg1_dur = 16'd5; req1 = 1'b1;
      tick();
      req1 = 1'b0;
      repeat (11) tick();
      msg2_data = 32'hFFFF_FFF4; msg2_mode = 2'd1; msg2_dur = 16'd2; msg2_blink = 1'b0; req2 = 1'b1;
      tick();
      req2 = 1'b0;
      check("pre_src", 32'(active_src), 32'd2);
      check("pre_data", w_seg_data, 32'hFFFF_FFF4);
      n1 = 0; n2 = 0;
      for (int k = 1; k <= 75; k++) begin
         tick();
         n1 += int'(done1);
         n2 += int'(done2);
         if (k == 19) check("pre_src19", 32'(active_src), 32'd2);
         if (k == 20) begin
            check("pre_done2", 32'(done2), 32'd1);
            check("replay_src", 32'(active_src), 32'd1);
            check("replay_data", w_seg_data, 32'hFFFF_FFF3);
         end
         if (k == 69) check("replay_src69", 32'(active_src), 32'd1);
         if (k == 70) check("replay_done1", 32'(done1), 32'd1);
      end
      check("pre_n_done1", 32'(n1), 32'd1);
      check("pre_n_done2", 32'(n2), 32'd1);

      // Blinking alert, dur 8
      msg2_data = 32'h0000_00A5; msg2_mode = 2'd0; msg2_dur = 16'd8; msg2_blink = 1'b1; req2 = 1'b1;
      tick();
      req2 = 1'b0;
      check("blink_first", w_seg_data, 32'h0000_00A5);
      for (int k = 1; k <= 80; k++) begin
         tick();
         if (k == 80)                  want = 32'h0000_1234;
         else if (((k / 20) % 2) == 1) want = 32'hFFFF_FFFF;
         else                          want = 32'h0000_00A5;
         check("blink_data", w_seg_data, want);
      end
      check("blink_done2", 32'(done2), 32'd1);
      msg2_blink = 1'b0;
      repeat (2) tick();

      // Retrigger at cycle 25 of a dur-3 info message
      msg1_data = 32'hFFFF_FF11; msg1_dur = 16'd3; req1 = 1'b1;
      tick();
      req1 = 1'b0;
      repeat (24) tick();
      msg1_data = 32'hFFFF_FF22; req1 = 1'b1;
      tick();
      req1 = 1'b0;
      check("retrig_data", w_seg_data, 32'hFFFF_FF22);
      n1 = 0;
      for (int k = 1; k <= 32; k++) begin
         tick();
         n1 += int'(done1);
         if (k == 5)  check("retrig_nodone30", 32'(done1), 32'd0);
         if (k == 30) check("retrig_done55", 32'(done1), 32'd1);
      end
      check("retrig_n_done1", 32'(n1), 32'd1);

      // Hold (dur 0) until clr_msg
      msg1_data = 32'hFFFF_FF33; msg1_dur = 16'd0; req1 = 1'b1;
      tick();
      req1 = 1'b0;
      repeat (500) tick();
      check("hold_src", 32'(active_src), 32'd1);
      check("hold_busy", 32'(busy), 32'd1);
      clr_msg = 1'b1;
      tick();
      clr_msg = 1'b0;
      check("clr_src", 32'(active_src), 32'd0);
      check("clr_busy", 32'(busy), 32'd0);
      check("clr_data", w_seg_data, 32'h0000_1234);
      check("clr_nodone", 32'(done1), 32'd0);
      tick();

      // clr_msg beats a same-cycle alert request
      msg2_data = 32'hFFFF_FF44; msg2_dur = 16'd2; clr_msg = 1'b1; req2 = 1'b1;
      tick();
      clr_msg = 1'b0; req2 = 1'b0;
      check("clrreq_src", 32'(active_src), 32'd0);
      check("clrreq_busy", 32'(busy), 32'd0);
      tick();
      check("clrreq_src2", 32'(active_src), 32'd0);

      // Async reset in the middle of a message
      msg1_data = 32'hFFFF_FF55; msg1_dur = 16'd5; req1 = 1'b1;
      tick();
      req1 = 1'b0;
      repeat (10) tick();
      #2 rst_n = 1'b0;
      #1;
      check("arst_data", w_seg_data, 32'h0);
      check("arst_src", 32'(active_src), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("arst_bg", w_seg_data, 32'h0000_1234);
      check("arst_src_after", 32'(active_src), 32'd0);

      // Random traffic against the model
      for (int c = 0; c < 4000; c++) begin
         req1 = ($urandom % 40) == 0;
         req2 = ($urandom % 70) == 0;
         clr_msg = ($urandom % 300) == 0;
         if (($urandom % 25) == 0) begin
            bg_data = $urandom;
            bg_mode = 2'($urandom % 2);
         end
         msg1_data = $urandom; msg1_mode = 2'($urandom % 2);
         msg1_dur = 16'($urandom_range(0, 6)); msg1_blink = 1'($urandom % 2);
         msg2_data = $urandom; msg2_mode = 2'($urandom % 2);
         msg2_dur = 16'($urandom_range(0, 6)); msg2_blink = 1'($urandom % 2);
         tick();
      end
      req1 = 1'b0; req2 = 1'b0; clr_msg = 1'b0;
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
- Owns the 32-bit data and 2-bit mode inputs of the 8-digit seven-segment scan driver, and shares them between requesters.
- Sources: a background value that is always present (live result / counter), plus two transient message sources: info (src1) and alert (src2).
- Each message is shown for a programmed number of milliseconds, optionally blinking; the display then reverts automatically.
- Alerts preempt info messages; a preempted info message is replayed afterwards.

Parameters:
- TICK_DIV, 100_000, clock cycles per 1 ms tick (100 MHz clock); set to 10 in simulation.
- BLINK_MS, 250, blink half-period in ms.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- bg_data  in  32  background display word (8 hex nibbles)
- bg_mode  in  2  background mode, driver encoding (0 = numeric, 1 = character)
- req1 / req2  in  1  single-cycle message request, info / alert
- msg1_data / msg2_data  in  32  message word, sampled when reqN = 1
- msg1_mode / msg2_mode  in  2  message mode, sampled when reqN = 1
- msg1_dur / msg2_dur  in  16  display time in ms, sampled when reqN = 1; 0 = hold until clr_msg
- msg1_blink / msg2_blink  in  1  blink enable, sampled when reqN = 1
- clr_msg  in  1  drop all messages and return to background
- w_seg_data  out  32  registered data to the scan driver
- w_seg_mode  out  2  registered mode to the scan driver
- active_src  out  2  0 = background, 1 = info, 2 = alert
- done1 / done2  out  1  one-cycle pulse when message N completes its full duration
- busy  out  1  high while any message is pending or being shown

Behaviour:
- Reset: state IDLE, both pend flags 0, timers 0, w_seg_data = 0, w_seg_mode = 0, active_src = 0, done1 = done2 = 0, busy = 0.
- Pending slots: reqN latches data/mode/dur/blink into slot N and sets pendN. A new reqN always overwrites slot N (newest wins). pendN clears only on completion of message N or on clr_msg.
- FSM states: IDLE, SHOW1, SHOW2. Next state is evaluated every cycle:
  - clr_msg = 1 -> IDLE, both pends cleared, no done pulse. clr_msg has priority over a same-cycle reqN; that request is discarded.
  - else pend2 (or req2 this cycle) -> SHOW2.
  - else pend1 (or req1 this cycle) -> SHOW1.
  - else IDLE.
- Preemption: SHOW1 with req2 -> SHOW2; pend1 stays set. When SHOW2 finishes, SHOW1 restarts with its full duration.
- Retrigger: reqN while in SHOWN overwrites slot N and restarts the timer and blink phase. The request in the same cycle as natural completion wins: no doneN, the message restarts.
- Timer: restarted (prescaler = 0, ms count = 0, blink phase = on) on every entry to SHOWN and on every retrigger.
- Completion: message N completes exactly dur × TICK_DIV cycles after timer restart. On completion: pendN cleared, doneN pulses on that edge, FSM moves on (to SHOW1 if pend1, else IDLE). dur = 0 never completes.
- Blink: with the blink bit set, the phase toggles every BLINK_MS ms counted from restart. In the off phase, w_seg_data = 32'hFFFF_FFFF and w_seg_mode = 0 (all digits blank). Blink does not affect the duration.
- Output latency:
  - The output registers load from the next-state selection, so the message appears on the edge after the cycle in which reqN is sampled (1-cycle latency).
  - In IDLE, bg_data/bg_mode changes pass through with 1-cycle latency.
- active_src and busy are registered together with the data, so they stay coherent with w_seg_data. busy = pend1 | pend2 after the update.
- Simultaneous req1 and req2 in IDLE: both latched; SHOW2 first, then SHOW1.
- Prescaler width and ms counter are 17 and 16 bits; no overflow is possible below the 16-bit dur.
- Asynchronous reset mid-message: all state is lost immediately and outputs return to their reset values; no done pulse.

Test Plan:
- TICK_DIV = 10, BLINK_MS = 2. Reset, bg_data = 32'h0000_1234, bg_mode = 0 -> outputs 0/0 during reset; 1 cycle after release: w_seg_data = 32'h0000_1234, active_src = 0, busy = 0.
- req1, msg1_data = 32'hFFFF_FFF2, mode = 1, dur = 3 -> next edge: w_seg_data = 32'hFFFF_FFF2, mode = 1, active_src = 1, busy = 1. done1 pulses exactly 30 cycles after the request edge; background returns the same edge.
- req1 with dur = 5, then req2 (dur = 2, data = 32'hFFFF_FFF4) 12 cycles later -> active_src = 2 for 20 cycles, done2, then SHOW1 replays the full 50 cycles, then done1. Exactly one done1.
- req2 with dur = 8, blink = 1 -> data alternates between message and 32'hFFFF_FFFF every 20 cycles, starting with the message; done2 at 80 cycles.
- req1 retriggered at cycle 25 of a dur = 3 message with new data -> new data shown, no done1 at cycle 30, done1 at 25 + 30.
- req1 with dur = 0, then clr_msg after 500 cycles; separately, clr_msg and req2 in the same cycle -> background restored on the next edge, busy = 0, no done pulses, req2 ignored.
